// File: rtl/match_scorer.sv
// match_scorer: match-level scorekeeper for the pong game.
// Win-line indications arrive from the VGA clock domain and are synchronised
// here. The module counts points, freezes the ball during the serve hold,
// and latches the winner once a player reaches WIN_SCORE.
module match_scorer #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       new_game,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       serve_hold,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [3:0]       WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             p1_s1, p1_s2, p1_s2_d;
    logic             p2_s1, p2_s2, p2_s2_d;
    logic             ng_s1, ng_s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;

    logic       p1_rise, p2_rise;
    logic [3:0] p1_inc, p2_inc;

    assign p1_rise = p1_s2 & ~p1_s2_d;
    assign p2_rise = p2_s2 & ~p2_s2_d;
    assign p1_inc  = p1_score + 4'd1;
    assign p2_inc  = p2_score + 4'd1;

    // Two-flop synchronisers for the asynchronous inputs plus the delayed copy for rise detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_s1   <= 1'b0;
            p1_s2   <= 1'b0;
            p1_s2_d <= 1'b0;
            p2_s1   <= 1'b0;
            p2_s2   <= 1'b0;
            p2_s2_d <= 1'b0;
            ng_s1   <= 1'b0;
            ng_s2   <= 1'b0;
        end else begin
            p1_s1   <= p1_win;
            p1_s2   <= p1_s1;
            p1_s2_d <= p1_s2;
            p2_s1   <= p2_win;
            p2_s2   <= p2_s1;
            p2_s2_d <= p2_s2;
            ng_s1   <= new_game;
            ng_s2   <= ng_s1;
        end
    end

    // Match sequencing: scoring in PLAY, serve lockout in HOLD, frozen result in OVER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PLAY;
            hold_cnt   <= '0;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            serve_hold <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            case (state)
                ST_PLAY: begin
                    // A pending new_game request masks any point on the same cycle
                    if (!ng_s2) begin
                        if (p1_rise && p2_rise) begin
                            // Simultaneous points count as a void rally
                            state      <= ST_HOLD;
                            serve_hold <= 1'b1;
                            hold_cnt   <= HOLD_LOAD;
                        end else if (p1_rise) begin
                            p1_score <= p1_inc;
                            if (p1_inc == WIN_VAL) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                                winner    <= 2'b01;
                            end else begin
                                state      <= ST_HOLD;
                                serve_hold <= 1'b1;
                                hold_cnt   <= HOLD_LOAD;
                            end
                        end else if (p2_rise) begin
                            p2_score <= p2_inc;
                            if (p2_inc == WIN_VAL) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                                winner    <= 2'b10;
                            end else begin
                                state      <= ST_HOLD;
                                serve_hold <= 1'b1;
                                hold_cnt   <= HOLD_LOAD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (ng_s2) begin
                        state      <= ST_PLAY;
                        serve_hold <= 1'b0;
                        hold_cnt   <= '0;
                        p1_score   <= 4'd0;
                        p2_score   <= 4'd0;
                    end else if (hold_cnt == '0 && !p1_s2 && !p2_s2) begin
                        // Only release once the engine has dropped both win lines
                        state      <= ST_PLAY;
                        serve_hold <= 1'b0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                ST_OVER: begin
                    if (ng_s2) begin
                        // Fresh match starts with a serve delay before the first rally
                        state      <= ST_HOLD;
                        serve_hold <= 1'b1;
                        hold_cnt   <= HOLD_LOAD;
                        p1_score   <= 4'd0;
                        p2_score   <= 4'd0;
                        game_over  <= 1'b0;
                        winner     <= 2'b00;
                    end
                end
                default: begin
                    state      <= ST_PLAY;
                    serve_hold <= 1'b0;
                    game_over  <= 1'b0;
                    winner     <= 2'b00;
                    hold_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_scorer.sv
// tb_match_scorer: directed scenarios plus a randomized run against a
// deadline-based behavioural model of the match rules.
module tb_match_scorer;
    localparam int WIN = 3;
    localparam int HC  = 8;
    localparam int M_PLAY = 0, M_HOLD = 1, M_OVER = 2;

    logic       clk = 1'b0;
    logic       rst, p1_win, p2_win, new_game;
    logic [3:0] p1_score, p2_score;
    logic       serve_hold, game_over;
    logic [1:0] winner;
    int         checks = 0;
    int         errors = 0;

    // Behavioural model state: input histories (bit0 = last edge), mode, hold deadline
    logic [2:0] m_h1, m_h2, m_hn;
    int         m_mode, m_deadline, m_cyc;
    logic [3:0] m_s1, m_s2;
    logic [1:0] m_win;

    always #5 clk = ~clk;

    match_scorer #(.WIN_SCORE(WIN), .HOLD_CYCLES(HC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .p1_win(p1_win), .p2_win(p2_win), .new_game(new_game),
        .p1_score(p1_score), .p2_score(p2_score), .serve_hold(serve_hold),
        .game_over(game_over), .winner(winner)
    );

    task automatic model_reset();
        m_h1 = 3'b0; m_h2 = 3'b0; m_hn = 3'b0;
        m_mode = M_PLAY; m_deadline = 0; m_cyc = 0;
        m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00;
    endtask

    // Apply the match rules for one clock edge; inputs act two edges after being sampled
    task automatic model_step();
        logic l1, l2, r1, r2, ng;
        m_cyc++;
        l1 = m_h1[1]; l2 = m_h2[1]; ng = m_hn[1];
        r1 = m_h1[1] & ~m_h1[2];
        r2 = m_h2[1] & ~m_h2[2];
        case (m_mode)
            M_PLAY: if (!ng) begin
                if (r1 && r2) begin
                    m_mode = M_HOLD; m_deadline = m_cyc + HC;
                end else if (r1) begin
                    m_s1++;
                    if (m_s1 == WIN) begin m_mode = M_OVER; m_win = 2'b01; end
                    else begin m_mode = M_HOLD; m_deadline = m_cyc + HC; end
                end else if (r2) begin
                    m_s2++;
                    if (m_s2 == WIN) begin m_mode = M_OVER; m_win = 2'b10; end
                    else begin m_mode = M_HOLD; m_deadline = m_cyc + HC; end
                end
            end
            M_HOLD: begin
                if (ng) begin m_s1 = 4'd0; m_s2 = 4'd0; m_mode = M_PLAY; end
                else if (m_cyc >= m_deadline && !l1 && !l2) m_mode = M_PLAY;
            end
            default: if (ng) begin
                m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00;
                m_mode = M_HOLD; m_deadline = m_cyc + HC;
            end
        endcase
        m_h1 = {m_h1[1:0], p1_win};
        m_h2 = {m_h2[1:0], p2_win};
        m_hn = {m_hn[1:0], new_game};
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; p1_win = 1'b0; p2_win = 1'b0; new_game = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Drive the given input levels for exactly one sampling edge
    task automatic pulse(input logic a, input logic b, input logic n);
        p1_win = a; p2_win = b; new_game = n;
        tick();
        p1_win = 1'b0; p2_win = 1'b0; new_game = 1'b0;
    endtask

    // Count edges until serve_hold drops, bounded
    task automatic wait_release(output int n);
        n = 0;
        while (serve_hold && n < 100) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; p1_win = 1'b0; p2_win = 1'b0; new_game = 1'b0;
        #1;
        checks++; if (p1_score !== 4'd0) begin errors++; $display("FAIL reset_p1_score got %0d want 0", p1_score); end
        checks++; if (p2_score !== 4'd0) begin errors++; $display("FAIL reset_p2_score got %0d want 0", p2_score); end
        tick(); tick();
        checks++; if (serve_hold !== 1'b0) begin errors++; $display("FAIL reset_serve_hold got %b want 0", serve_hold); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", game_over); end
        checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b want 00", winner); end
        rst = 1'b0;
    endtask

    task automatic test_point_hold();
        int n;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (p1_score !== 4'd0) begin errors++; $display("FAIL point_latency_e1 got %0d want 0", p1_score); end
        tick();
        checks++; if (p1_score !== 4'd1) begin errors++; $display("FAIL point_p1_score got %0d want 1", p1_score); end
        checks++; if (p2_score !== 4'd0) begin errors++; $display("FAIL point_p2_score got %0d want 0", p2_score); end
        checks++; if (serve_hold !== 1'b1) begin errors++; $display("FAIL point_serve_hold got %b want 1", serve_hold); end
        wait_release(n);
        checks++; if (n != HC) begin errors++; $display("FAIL point_hold_len got %0d want %0d", n, HC); end
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0); tick(); tick();
        pulse(1'b0, 1'b1, 1'b0); tick(); tick(); tick();
        checks++; if (p2_score !== 4'd0) begin errors++; $display("FAIL lockout_p2_score got %0d want 0", p2_score); end
        checks++; if (serve_hold !== 1'b1) begin errors++; $display("FAIL lockout_still_hold got %b want 1", serve_hold); end
        wait_release(n);
        checks++; if (p2_score !== 4'd0) begin errors++; $display("FAIL lockout_p2_after got %0d want 0", p2_score); end
        // Long win level: hold must outlast the counter until the line drops
        do_reset();
        p1_win = 1'b1;
        repeat (20) tick();
        p1_win = 1'b0;
        tick();
        wait_release(n);
        checks++; if (n != 2) begin errors++; $display("FAIL long_level_release got %0d want 2", n); end
        checks++; if (p1_score !== 4'd1) begin errors++; $display("FAIL long_level_one_point got %0d want 1", p1_score); end
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        pulse(1'b1, 1'b1, 1'b0); tick(); tick();
        checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin errors++; $display("FAIL tie_scores got %0d/%0d want 0/0", p1_score, p2_score); end
        checks++; if (serve_hold !== 1'b1) begin errors++; $display("FAIL tie_serve_hold got %b want 1", serve_hold); end
        wait_release(n);
        checks++; if (n != HC) begin errors++; $display("FAIL tie_hold_len got %0d want %0d", n, HC); end
    endtask

    task automatic test_win();
        int n;
        do_reset();
        repeat (WIN) begin pulse(1'b0, 1'b1, 1'b0); tick(); tick(); wait_release(n); end
        checks++; if (p2_score !== 4'd3) begin errors++; $display("FAIL win_p2_score got %0d want 3", p2_score); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_game_over got %b want 1", game_over); end
        checks++; if (winner !== 2'b10) begin errors++; $display("FAIL win_winner got %b want 10", winner); end
        checks++; if (serve_hold !== 1'b0) begin errors++; $display("FAIL win_serve_hold got %b want 0", serve_hold); end
        pulse(1'b1, 1'b0, 1'b0); repeat (4) tick();
        checks++; if (p1_score !== 4'd0) begin errors++; $display("FAIL over_frozen_p1 got %0d want 0", p1_score); end
        checks++; if (winner !== 2'b10) begin errors++; $display("FAIL over_winner_held got %b want 10", winner); end
    endtask

    task automatic test_new_game_over();
        int n;
        pulse(1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL ng_latency_e1 got %b want 1", game_over); end
        tick();
        checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin errors++; $display("FAIL ng_scores got %0d/%0d want 0/0", p1_score, p2_score); end
        checks++; if (winner !== 2'b00 || game_over !== 1'b0) begin errors++; $display("FAIL ng_result got %b/%b want 00/0", winner, game_over); end
        checks++; if (serve_hold !== 1'b1) begin errors++; $display("FAIL ng_serve_hold got %b want 1", serve_hold); end
        wait_release(n);
        checks++; if (n != HC) begin errors++; $display("FAIL ng_hold_len got %0d want %0d", n, HC); end
        pulse(1'b1, 1'b0, 1'b0); tick(); tick();
        checks++; if (p1_score !== 4'd1) begin errors++; $display("FAIL ng_then_play got %0d want 1", p1_score); end
    endtask

    task automatic test_new_game_hold();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0); tick(); tick();
        pulse(1'b0, 1'b0, 1'b1); tick(); tick();
        checks++; if (p1_score !== 4'd0) begin errors++; $display("FAIL ng_hold_score got %0d want 0", p1_score); end
        checks++; if (serve_hold !== 1'b0) begin errors++; $display("FAIL ng_hold_release got %b want 0", serve_hold); end
        pulse(1'b1, 1'b0, 1'b1); tick(); tick();
        checks++; if (p1_score !== 4'd0 || serve_hold !== 1'b0) begin errors++; $display("FAIL ng_priority got %0d/%b want 0/0", p1_score, serve_hold); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0); tick(); tick(); wait_release(n);
        pulse(1'b1, 1'b0, 1'b0); tick(); tick();
        checks++; if (p1_score !== 4'd2 || serve_hold !== 1'b1) begin errors++; $display("FAIL pre_async_state got %0d/%b want 2/1", p1_score, serve_hold); end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (p1_score !== 4'd0 || serve_hold !== 1'b0) begin errors++; $display("FAIL async_reset got %0d/%b want 0/0", p1_score, serve_hold); end
        #1 rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] exp_w;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) p1_win = ~p1_win;
            if ($urandom_range(0, 11) == 0) p2_win = ~p2_win;
            if (!p1_win && !p2_win && $urandom_range(0, 29) == 0) begin p1_win = 1'b1; p2_win = 1'b1; end
            new_game = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            model_step();
            #1;
            exp_w = m_win;
            checks++; if (p1_score !== m_s1) begin errors++; $display("FAIL rnd_p1_score cyc %0d got %0d want %0d", i, p1_score, m_s1); end
            checks++; if (p2_score !== m_s2) begin errors++; $display("FAIL rnd_p2_score cyc %0d got %0d want %0d", i, p2_score, m_s2); end
            checks++; if (serve_hold !== (m_mode == M_HOLD)) begin errors++; $display("FAIL rnd_serve_hold cyc %0d got %b want %b", i, serve_hold, (m_mode == M_HOLD)); end
            checks++; if (game_over !== (m_mode == M_OVER)) begin errors++; $display("FAIL rnd_game_over cyc %0d got %b want %b", i, game_over, (m_mode == M_OVER)); end
            checks++; if (winner !== exp_w) begin errors++; $display("FAIL rnd_winner cyc %0d got %b want %b", i, winner, exp_w); end
        end
        p1_win = 1'b0; p2_win = 1'b0; new_game = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_point_hold();
        test_lockout();
        test_tie();
        test_win();
        test_new_game_over();
        test_new_game_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
